// File: rtl/and_unit_rr_arbiter_if.sv
// Request/response bundle for the shared AND unit arbiter.
// Master drives operands and consumes results; slave is the arbiter.
interface and_unit_rr_arbiter_if #(
    parameter int REQ_CNT = 4,
    parameter int DATA_W  = 16
);
    localparam int ID_W = $clog2(REQ_CNT);

    logic [REQ_CNT-1:0]        req_valid;
    logic [REQ_CNT-1:0]        req_ready;
    logic [REQ_CNT*DATA_W-1:0] req_a;
    logic [REQ_CNT*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/and_unit_rr_arbiter.sv
// Round-robin arbiter sharing one bitwise-AND datapath between
// REQ_CNT requesters, with a one-entry registered result stage.
module and_unit_rr_arbiter #(
    parameter int REQ_CNT = 4,
    parameter int DATA_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    and_unit_rr_arbiter_if.slave bus,
    output logic                 busy,
    output logic [15:0]          txn_count
);
    localparam int ID_W = $clog2(REQ_CNT);
    localparam logic [ID_W:0] CNT_W1 = (ID_W+1)'(REQ_CNT);

    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_hit;
    logic              can_accept;
    logic              accept;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Scan from the requester after the last winner, wrapping once.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant_hit = 1'b0;
        grant_id  = '0;
        sel_a     = '0;
        sel_b     = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= REQ_CNT; k++) begin
            sum = {1'b0, last_grant} + (ID_W+1)'(k);
            if (sum >= CNT_W1) sum = sum - CNT_W1;
            idx = sum[ID_W-1:0];
            if (!grant_hit && bus.req_valid[idx]) begin
                grant_hit = 1'b1;
                grant_id  = idx;
                sel_a     = bus.req_a[idx*DATA_W +: DATA_W];
                sel_b     = bus.req_b[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign can_accept = !bus.rsp_valid || bus.rsp_ready;
    assign accept     = rst && grant_hit && can_accept;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_id] = 1'b1;
    end

    assign busy = bus.rsp_valid || (|bus.req_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            last_grant    <= ID_W'(REQ_CNT-1);
            txn_count     <= '0;
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= sel_a & sel_b;
            bus.rsp_id    <= grant_id;
            last_grant    <= grant_id;
            txn_count     <= txn_count + 16'd1;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_and_unit_rr_arbiter.sv
// Directed bench for and_unit_rr_arbiter with a per-cycle
// reference model and literal checkpoints.
module tb_and_unit_rr_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] txn_count;

    and_unit_rr_arbiter_if #(.REQ_CNT(N), .DATA_W(W)) bus ();

    and_unit_rr_arbiter #(.REQ_CNT(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: state after the most recent edge.
    int          m_last;
    bit          m_valid;
    logic [15:0] m_data;
    int          m_id;
    logic [15:0] m_cnt;

    function automatic int find_grant();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (rst) begin
            g = find_grant();
            if (g >= 0 && (!m_valid || bus.rsp_ready)) r[g] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_last  = N - 1;
            m_valid = 0;
            m_data  = '0;
            m_id    = 0;
            m_cnt   = '0;
        end else begin
            int g;
            g = find_grant();
            if (g >= 0 && (!m_valid || bus.rsp_ready)) begin
                m_data  = bus.req_a[g*W +: W] & bus.req_b[g*W +: W];
                m_id    = g;
                m_valid = 1;
                m_last  = g;
                m_cnt   = m_cnt + 16'd1;
            end else if (m_valid && bus.rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("m_req_ready", 32'(bus.req_ready), 32'(exp_ready()));
        chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        chk("m_rsp_data", 32'(bus.rsp_data), 32'(m_data));
        chk("m_rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("m_txn_count", 32'(txn_count), 32'(m_cnt));
        chk("m_busy", 32'(busy), 32'(m_valid || (|bus.req_valid)));
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 4'($urandom);
        bus.req_a     = 64'({$urandom, $urandom});
        bus.req_b     = 64'({$urandom, $urandom});
        bus.rsp_ready = 1'($urandom);
        repeat (3) cyc();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_txn_count", 32'(txn_count), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = 16'h1111 * 16'(i + 1);
            bus.req_b[i*W +: W] = 16'hFFFF;
        end
        rst = 1'b1;
        #1;
        chk("release_ready", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        cyc();

        // single request
        bus.req_valid       = 4'b0100;
        bus.req_a[2*W +: W] = 16'hF0F0;
        bus.req_b[2*W +: W] = 16'h3C3C;
        cyc();
        chk("single_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_data", 32'(bus.rsp_data), 32'h3030);
        chk("single_id", 32'(bus.rsp_id), 32'd2);
        chk("single_cnt", 32'(txn_count), 32'd1);
        bus.req_valid = '0;
        cyc();
        chk("single_drop", 32'(bus.rsp_valid), 32'd0);

        // move pointer to 3 so rotation starts at 0
        bus.req_valid = 4'b1000;
        cyc();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr_id", 32'(bus.rsp_id), 32'(i % N));
            chk("rr_valid", 32'(bus.rsp_valid), 32'd1);
        end
        chk("rr_cnt", 32'(txn_count), 32'd10);

        // backpressure
        bus.req_valid = 4'b0010;
        cyc();
        chk("bp_id1", 32'(bus.rsp_id), 32'd1);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1010;
        repeat (5) begin
            cyc();
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_hold_id", 32'(bus.rsp_id), 32'd1);
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        cyc();
        chk("bp_next3", 32'(bus.rsp_id), 32'd3);
        cyc();
        chk("bp_next1", 32'(bus.rsp_id), 32'd1);
        chk("bp_cnt", 32'(txn_count), 32'd13);
        bus.req_valid = '0;
        cyc();
        chk("bp_idle", 32'(bus.rsp_valid), 32'd0);

        // skip from last_grant=3
        bus.req_valid = 4'b1000;
        cyc();
        bus.req_valid = 4'b0110;
        cyc();
        chk("skip_id", 32'(bus.rsp_id), 32'd1);
        chk("skip_cnt", 32'(txn_count), 32'd15);

        // counter wrap
        bus.req_valid = 4'b1111;
        repeat (65520) cyc();
        chk("wrap_ffff", 32'(txn_count), 32'hFFFF);
        cyc();
        chk("wrap_zero", 32'(txn_count), 32'h0000);

        // reset in the middle of a stall
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        cyc();
        chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_data", 32'(bus.rsp_data), 32'd0);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        chk("post_rst_id", 32'(bus.rsp_id), 32'd3);
        chk("post_rst_cnt", 32'(txn_count), 32'd1);
        bus.req_valid = '0;
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
